// File: rtl/keypad_key_encoder.sv
// Turns debounced keypad presses into 4-bit key codes and queues them in a
// fall-through FIFO that the consumer drains through a valid/ready handshake.
module keypad_key_encoder #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned ERRW  = 8
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            db_in,
    input  logic [3:0]      col_in,
    input  logic [3:0]      row_in,
    input  logic            key_ready,
    input  logic            clr_ovf,
    output logic            key_valid,
    output logic [3:0]      key_code,
    output logic            key_held,
    output logic            err_pulse,
    output logic [ERRW-1:0] err_count,
    output logic            overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic          db_prev;
    logic          press;
    logic          shape_ok;
    logic [1:0]    row_idx;
    logic [1:0]    col_idx;
    logic [3:0]    new_code;
    logic          valid_ev;
    logic          invalid_ev;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

    always_comb begin
        row_idx = '0;
        col_idx = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (row_in[i]) row_idx = 2'(i);
            if (col_in[i]) col_idx = 2'(i);
        end
    end

    assign press      = db_in & ~db_prev;
    assign shape_ok   = is_onehot4(row_in) & is_onehot4(col_in);
    assign new_code   = {row_idx, col_idx};
    assign valid_ev   = press & shape_ok;
    assign invalid_ev = press & ~shape_ok;

    assign full      = (count == (AW + 1)'(DEPTH));
    assign key_valid = (count != '0);
    assign key_code  = key_valid ? mem[rd_ptr] : 4'd0;
    assign pop       = key_valid & key_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push      = valid_ev & (~full | pop);
    assign drop      = valid_ev & full & ~pop;

    // db_prev resets high so a key still held at reset release is not an event.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            db_prev   <= 1'b1;
            key_held  <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
        end else begin
            db_prev   <= db_in;
            key_held  <= db_in;
            err_pulse <= invalid_ev;
            if (invalid_ev && (err_count != '1))
                err_count <= err_count + 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= new_code;
    end

endmodule
